// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl -- commit-side trap controller
//
// Purpose:
//   Gathers exception reports from the writeback ports and keeps only the
//   oldest pending one, where age is measured from the current ROB head. When
//   that instruction reaches commit, or when an interrupt is taken at a commit
//   boundary, the block issues a single trap redirect pulse. It then stalls
//   commit until the pipeline flush has completed.
//
// Configuration macros:
//   BAD_DIVISOR_TRAP_EN  defined: cause 24 (badDivisor) is treated like any
//                        other exception. Undefined (default): reports with
//                        cause 24 are dropped at the input.
//   ROB_SIZE             ROB depth; defaults to 64. Must be a power of 2.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   i_report_*           per-port exception report (valid, ROB index, cause, tval)
//   i_rob_head           current oldest ROB entry (reference point for age)
//   i_squash_*           mispredict squash; entries strictly younger are killed
//   i_commit_*           ROB head commit request (valid, index, pc)
//   i_irq_pending/cause  enabled interrupt pending and its cause code
//   i_mtvec              mtvec CSR; [1:0] selects direct/vectored mode
//   i_flush_done         pipeline flush finished
//   o_commit_stall       blocks commit of the head this cycle
//   o_trap_*             one-cycle trap pulse with cause/epc/tval/target
//   o_busy               controller is in TRAP or FLUSH
// -----------------------------------------------------------------------------
`ifndef ROB_SIZE
`define ROB_SIZE 64
`endif

module trap_ctrl #(
    parameter int NUM_REPORT = 3,
    parameter int ROB_SIZE   = `ROB_SIZE,
    parameter int XLEN       = 64,
    localparam int IDX_W     = $clog2(ROB_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REPORT-1:0]                i_report_vld,
    input  logic [NUM_REPORT-1:0][IDX_W-1:0]     i_report_robIdx,
    input  logic [NUM_REPORT-1:0][5:0]           i_report_cause,
    input  logic [NUM_REPORT-1:0][XLEN-1:0]      i_report_tval,
    input  logic [IDX_W-1:0]                     i_rob_head,
    input  logic                                 i_squash_vld,
    input  logic [IDX_W-1:0]                     i_squash_robIdx,
    input  logic                                 i_commit_vld,
    input  logic [IDX_W-1:0]                     i_commit_robIdx,
    input  logic [XLEN-1:0]                      i_commit_pc,
    input  logic                                 i_irq_pending,
    input  logic [5:0]                           i_irq_cause,
    input  logic [XLEN-1:0]                      i_mtvec,
    input  logic                                 i_flush_done,
    output logic                                 o_commit_stall,
    output logic                                 o_trap_vld,
    output logic                                 o_trap_is_irq,
    output logic [5:0]                           o_trap_cause,
    output logic [XLEN-1:0]                      o_trap_epc,
    output logic [XLEN-1:0]                      o_trap_tval,
    output logic [XLEN-1:0]                      o_trap_target,
    output logic                                 o_busy
);

    typedef enum logic [1:0] {IDLE, TRAP, FLUSH} state_e;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic [5:0]       cause;
        logic [XLEN-1:0]  tval;
    } held_t;

    localparam logic [5:0] CAUSE_BAD_DIVISOR = 6'd24;

    state_e          state_q;
    held_t           held_q, held_d;
    logic            trap_vld_q, is_irq_q;
    logic [5:0]      cause_q;
    logic [XLEN-1:0] epc_q, tval_q, target_q;

    // Distance from the ROB head; the subtraction wraps because ROB_SIZE is a
    // power of 2, so a smaller value is always an older instruction.
    function automatic logic [IDX_W-1:0] age(input logic [IDX_W-1:0] idx,
                                             input logic [IDX_W-1:0] head);
        return idx - head;
    endfunction

    logic [IDX_W-1:0]                 sq_age, held_age, pick_age;
    logic [NUM_REPORT-1:0][IDX_W-1:0] rep_age;
    logic [NUM_REPORT-1:0]            rep_ok;
    logic                             pick_vld;
    logic [IDX_W-1:0]                 pick_idx;
    logic [5:0]                       pick_cause;
    logic [XLEN-1:0]                  pick_tval;
    logic                             take_exc, take_irq;
    logic [XLEN-1:0]                  trap_base, irq_target;

    assign sq_age   = age(i_squash_robIdx, i_rob_head);
    assign held_age = age(held_q.idx, i_rob_head);

    // Filter reports: squashed ones (strictly younger than the squash point)
    // and, unless enabled, badDivisor reports never compete for age.
    always_comb begin
        for (int p = 0; p < NUM_REPORT; p++) begin
            rep_age[p] = age(i_report_robIdx[p], i_rob_head);
            rep_ok[p]  = i_report_vld[p] && !(i_squash_vld && (rep_age[p] > sq_age));
`ifndef BAD_DIVISOR_TRAP_EN
            if (i_report_cause[p] == CAUSE_BAD_DIVISOR) begin
                rep_ok[p] = 1'b0;
            end
`endif
        end
    end

    // Oldest valid report; strict compare keeps the lowest port on a tie.
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pick_vld   = 1'b0;
        pick_idx   = '0;
        pick_cause = '0;
        pick_tval  = '0;
        pick_age   = '0;
        for (int p = 0; p < NUM_REPORT; p++) begin
            if (rep_ok[p] && (!pick_vld || (rep_age[p] < pick_age))) begin
                pick_vld   = 1'b1;
                pick_idx   = i_report_robIdx[p];
                pick_cause = i_report_cause[p];
                pick_tval  = i_report_tval[p];
                pick_age   = rep_age[p];
            end
        end
    end

    assign take_exc = (state_q == IDLE) && i_commit_vld && held_q.vld
                      && (i_commit_robIdx == held_q.idx);
    // An exception on the head always wins over an interrupt.
    assign take_irq = (state_q == IDLE) && !take_exc && i_commit_vld && i_irq_pending;

    always_comb begin
        held_d = held_q;
        if (i_squash_vld && held_q.vld && (held_age > sq_age)) begin
            held_d.vld = 1'b0;
        end
        if (pick_vld && (!held_d.vld || (pick_age < held_age))) begin
            held_d = '{vld: 1'b1, idx: pick_idx, cause: pick_cause, tval: pick_tval};
        end
        // Once a trap is triggered, nothing older than the flush can survive it.
        if ((state_q != IDLE) || take_exc || take_irq) begin
            held_d.vld = 1'b0;
        end
    end

    assign trap_base  = {i_mtvec[XLEN-1:2], 2'b00};
    assign irq_target = trap_base + (XLEN'(i_irq_cause) << 2);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            held_q     <= '0;
            trap_vld_q <= 1'b0;
            is_irq_q   <= 1'b0;
            cause_q    <= '0;
            epc_q      <= '0;
            tval_q     <= '0;
            target_q   <= '0;
        end else begin
            held_q     <= held_d;
            trap_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_exc) begin
                        state_q    <= TRAP;
                        trap_vld_q <= 1'b1;
                        is_irq_q   <= 1'b0;
                        cause_q    <= held_q.cause;
                        epc_q      <= i_commit_pc;
                        tval_q     <= held_q.tval;
                        target_q   <= trap_base;
                    end else if (take_irq) begin
                        state_q    <= TRAP;
                        trap_vld_q <= 1'b1;
                        is_irq_q   <= 1'b1;
                        cause_q    <= i_irq_cause;
                        epc_q      <= i_commit_pc;
                        tval_q     <= '0;
                        target_q   <= (i_mtvec[1:0] == 2'b01) ? irq_target : trap_base;
                    end
                end
                TRAP:    state_q <= FLUSH;
                FLUSH:   if (i_flush_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_commit_stall = rst && ((state_q != IDLE) || take_exc || take_irq);
    assign o_trap_vld     = trap_vld_q;
    assign o_trap_is_irq  = is_irq_q;
    assign o_trap_cause   = cause_q;
    assign o_trap_epc     = epc_q;
    assign o_trap_tval    = tval_q;
    assign o_trap_target  = target_q;
    assign o_busy         = (state_q != IDLE);

endmodule
